// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA constants for the fetch unit and the control decoder:
// opcodes, instruction field positions, fetch FSM states.
package instr_fetch_unit_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'hA;
  localparam logic [3:0] OP_BNE = 4'hE;

  localparam int INSTR_W = 16;
  localparam int FIELD_W = 4;
  localparam int OP_LSB  = 12;
  localparam int RS_LSB  = 8;
  localparam int RT_LSB  = 4;
  localparam int RD_LSB  = 0;

  typedef enum logic [1:0] {REQ, WAIT, HOLD, HALT} fetch_state_e;

  function automatic logic opcode_is_legal(input logic [3:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_LW, OP_SW, OP_BNE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: one outstanding 16-bit fetch, presents decoded fields
// to decode over valid/ready, applies branch redirects, halts on bad opcode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [15:0]       imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        op_code,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [3:0]        rd_imm,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              illegal_op
);

  fetch_state_e        state, state_d;
  logic [ADDR_W-1:0]   pc, pc_d;
  logic [ADDR_W-1:0]   ipc, ipc_d;
  logic [INSTR_W-1:0]  ir, ir_d;
  logic                discard, discard_d;
  logic                req_vld, req_vld_d;
  logic                iv, iv_d;
  logic                ill, ill_d;

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    ipc_d     = ipc;
    ir_d      = ir;
    discard_d = discard;
    iv_d      = iv;
    ill_d     = ill;
    case (state)
      REQ: begin
        if (branch_taken)                  pc_d = branch_target;
        else if (req_vld && imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (branch_taken) begin
          pc_d = branch_target;
          // A response landing with the redirect is the in-flight word itself:
          // drop it now rather than waiting for a response that never comes.
          if (imem_rsp_valid) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (discard) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            ir_d  = imem_rsp_data;
            ipc_d = pc;
            if (opcode_is_legal(imem_rsp_data[OP_LSB +: FIELD_W])) begin
              iv_d    = 1'b1;
              pc_d    = pc + ADDR_W'(1);
              state_d = HOLD;
            end else begin
              ill_d   = 1'b1;
              state_d = HALT;
            end
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          iv_d    = 1'b0;
          pc_d    = branch_target;
          state_d = REQ;
        end else if (instr_ready) begin
          iv_d    = 1'b0;
          state_d = REQ;
        end
      end
      HALT: ;
      default: state_d = HALT;
    endcase
    // Request valid is registered so it is low throughout reset.
    req_vld_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= REQ;
      pc      <= RESET_PC;
      ipc     <= '0;
      ir      <= '0;
      discard <= 1'b0;
      req_vld <= 1'b0;
      iv      <= 1'b0;
      ill     <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      ipc     <= ipc_d;
      ir      <= ir_d;
      discard <= discard_d;
      req_vld <= req_vld_d;
      iv      <= iv_d;
      ill     <= ill_d;
    end
  end

  assign imem_req_valid = req_vld;
  assign imem_addr      = pc;
  assign instr_valid    = iv;
  assign instr_pc       = ipc;
  assign illegal_op     = ill;
  assign op_code        = ir[OP_LSB +: FIELD_W];
  assign rs             = ir[RS_LSB +: FIELD_W];
  assign rt             = ir[RT_LSB +: FIELD_W];
  assign rd_imm         = ir[RD_LSB +: FIELD_W];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder model plus scenario tasks and
// a randomized run checked against an expected-PC-stream reference.
module tb_instr_fetch_unit;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req_valid, imem_req_ready;
  logic [AW-1:0] imem_addr;
  logic          imem_rsp_valid;
  logic [15:0]   imem_rsp_data;
  logic          instr_valid, instr_ready;
  logic [3:0]    op_code, rs, rt, rd_imm;
  logic [AW-1:0] instr_pc;
  logic          branch_taken;
  logic [AW-1:0] branch_target;
  logic          illegal_op;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mem [256];
  int mem_lat = 0;
  bit mem_rand = 0;
  int hs_q[$];
  logic [3:0] legal_ops [8] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'hA, 4'hE};

  instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op_code(op_code), .rs(rs), .rt(rt), .rd_imm(rd_imm), .instr_pc(instr_pc),
    .branch_taken(branch_taken), .branch_target(branch_target), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Memory: accepts one request at a time, answers after mem_lat extra cycles.
  initial begin : mem_model
    int cnt;
    bit busy;
    logic [AW-1:0] paddr;
    busy = 0; cnt = 0; paddr = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (!rst_n) busy = 0;
      else if (busy) begin
        if (cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem[paddr];
          busy = 0;
        end else cnt--;
      end
      imem_req_ready = !busy && (mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        busy = 1;
        paddr = imem_addr;
        hs_q.push_back(int'(imem_addr));
        cnt = mem_rand ? int'($urandom_range(0, 2)) : mem_lat;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    instr_ready = 1'b0;
    mem_lat = 0;
    mem_rand = 0;
    repeat (2) tick();
    hs_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL %s: instr_valid never rose within 40 cycles", name);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; branch_taken = 1'b0; branch_target = '0; instr_ready = 1'b0;
    tick();
    vectors++;
    if ({imem_req_valid, instr_valid, illegal_op, op_code, rs, rt, rd_imm, instr_pc} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b iv=%b ill=%b word=%h pc=%h, want all 0",
               imem_req_valid, instr_valid, illegal_op, {op_code, rs, rt, rd_imm}, instr_pc);
    end
    vectors++;
    if (imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_addr: got %h want 00", imem_addr);
    end
  endtask

  task automatic test_basic;
    int seen, t[2];
    logic [15:0] w[2];
    logic [AW-1:0] p[2];
    seen = 0;
    mem[0] = 16'h2123; mem[1] = 16'h6456;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      tick();
      if (instr_valid) begin
        w[seen] = {op_code, rs, rt, rd_imm}; p[seen] = instr_pc; t[seen] = i; seen++;
      end
    end
    vectors++;
    if (seen != 2) begin
      miscompares++;
      $display("FAIL basic_count: got %0d instructions want 2", seen);
    end else begin
      vectors++;
      if (w[0] !== 16'h2123 || p[0] !== 8'h00) begin
        miscompares++;
        $display("FAIL basic_first: got %h@%h want 2123@00", w[0], p[0]);
      end
      vectors++;
      if (w[1] !== 16'h6456 || p[1] !== 8'h01) begin
        miscompares++;
        $display("FAIL basic_second: got %h@%h want 6456@01", w[1], p[1]);
      end
      vectors++;
      if (t[1] - t[0] != 3) begin
        miscompares++;
        $display("FAIL basic_rate: got %0d cycles per instr want 3", t[1] - t[0]);
      end
    end
    vectors++;
    if (hs_q.size() < 2 || hs_q[0] != 0 || hs_q[1] != 1) begin
      miscompares++;
      $display("FAIL basic_addr: request address sequence wrong, count %0d", hs_q.size());
    end
  endtask

  task automatic test_stall;
    bit ok;
    int hs0, bad;
    mem[0] = 16'h8A12;
    do_reset();
    wait_valid("stall_valid", ok);
    if (ok) begin
      hs0 = hs_q.size(); bad = 0;
      for (int i = 0; i < 5; i++) begin
        if (!instr_valid || {op_code, rs, rt, rd_imm} !== 16'h8A12 || imem_req_valid) bad++;
        tick();
      end
      vectors++;
      if (bad != 0 || hs_q.size() != hs0) begin
        miscompares++;
        $display("FAIL stall_hold: got %0d unstable cycles, %0d new requests, want 0 and 0",
                 bad, hs_q.size() - hs0);
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      vectors++;
      if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 8'h01) begin
        miscompares++;
        $display("FAIL stall_accept: got iv=%b req=%b addr=%h want 0 1 01",
                 instr_valid, imem_req_valid, imem_addr);
      end
    end
  endtask

  task automatic test_redirect_wait;
    bit ok;
    mem[0] = 16'h1111; mem[8'h40] = 16'h2345;
    do_reset();
    mem_lat = 3;
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && hs_q.size() == 0; i++) tick();
    tick();
    branch_taken = 1'b1; branch_target = 8'h40;
    tick();
    branch_taken = 1'b0;
    wait_valid("rwait_valid", ok);
    if (ok) begin
      vectors++;
      if (instr_pc !== 8'h40 || {op_code, rs, rt, rd_imm} !== 16'h2345) begin
        miscompares++;
        $display("FAIL rwait_first: got %h@%h want 2345@40", {op_code, rs, rt, rd_imm}, instr_pc);
      end
    end
    vectors++;
    if (hs_q.size() < 2 || hs_q[1] != 'h40) begin
      miscompares++;
      $display("FAIL rwait_addr: second request address wrong, count %0d", hs_q.size());
    end
  endtask

  task automatic test_redirect_hold;
    bit ok;
    int hs0;
    mem[0] = 16'h7001; mem[8'h20] = 16'hE0F5;
    do_reset();
    wait_valid("rhold_valid", ok);
    if (ok) begin
      hs0 = hs_q.size();
      instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 8'h20;
      tick();
      branch_taken = 1'b0;
      vectors++;
      if (instr_valid !== 1'b0 || imem_addr !== 8'h20) begin
        miscompares++;
        $display("FAIL rhold_drop: got iv=%b addr=%h want 0 20", instr_valid, imem_addr);
      end
      wait_valid("rhold_next", ok);
      if (ok) begin
        vectors++;
        if (instr_pc !== 8'h20 || {op_code, rs, rt, rd_imm} !== 16'hE0F5 || hs_q[hs0] != 'h20) begin
          miscompares++;
          $display("FAIL rhold_target: got %h@%h want E0F5@20", {op_code, rs, rt, rd_imm}, instr_pc);
        end
      end
    end
  endtask

  task automatic test_illegal;
    int bad, hs0;
    mem[0] = 16'h0000; mem[1] = 16'h3ABC;
    do_reset();
    instr_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (instr_valid && op_code == 4'h3) bad++;
    end
    vectors++;
    if (bad != 0 || illegal_op !== 1'b1 || imem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_halt: got %0d illegal presents ill=%b req=%b want 0 1 0",
               bad, illegal_op, imem_req_valid);
    end
    hs0 = hs_q.size(); bad = 0;
    for (int i = 0; i < 10; i++) begin
      branch_taken = i[0]; branch_target = 8'h10;
      tick();
      if (imem_req_valid || instr_valid || !illegal_op) bad++;
    end
    branch_taken = 1'b0;
    vectors++;
    if (bad != 0 || hs_q.size() != hs0) begin
      miscompares++;
      $display("FAIL illegal_sticky: got %0d bad cycles, %0d requests want 0 0", bad, hs_q.size() - hs0);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (illegal_op !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_clear: got %b want 0", illegal_op);
    end
  endtask

  task automatic test_wrap_async;
    bit ok;
    int hs0;
    logic [15:0] w0;
    logic [AW-1:0] p0;
    mem[8'hFF] = 16'h2AB1; mem[0] = 16'h6CD2; mem[1] = 16'h8001;
    do_reset();
    branch_taken = 1'b1; branch_target = 8'hFF;
    tick();
    branch_taken = 1'b0;
    wait_valid("wrap_first", ok);
    if (!ok) return;
    w0 = {op_code, rs, rt, rd_imm}; p0 = instr_pc;
    instr_ready = 1'b1;
    tick();
    wait_valid("wrap_second", ok);
    if (!ok) return;
    vectors++;
    if (w0 !== 16'h2AB1 || p0 !== 8'hFF || {op_code, rs, rt, rd_imm} !== 16'h6CD2 || instr_pc !== 8'h00) begin
      miscompares++;
      $display("FAIL wrap_seq: got %h@%h then %h@%h want 2AB1@FF then 6CD2@00",
               w0, p0, {op_code, rs, rt, rd_imm}, instr_pc);
    end
    mem_lat = 4;
    hs0 = hs_q.size();
    for (int i = 0; i < 20 && hs_q.size() == hs0; i++) tick();
    tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({imem_req_valid, instr_valid, illegal_op, op_code, rs, rt, rd_imm, instr_pc} !== '0 ||
        imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: got req=%b iv=%b word=%h pc=%h addr=%h want all 0",
               imem_req_valid, instr_valid, {op_code, rs, rt, rd_imm}, instr_pc, imem_addr);
    end
    tick();
    hs_q.delete();
    mem_lat = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 20 && hs_q.size() == 0; i++) tick();
    vectors++;
    if (hs_q.size() == 0 || hs_q[0] != 0) begin
      miscompares++;
      $display("FAIL async_restart: first request address wrong, count %0d", hs_q.size());
    end
  endtask

  // Reference: presented instructions form the stream exp_pc, exp_pc+1, ...
  // restarted at branch_target by every redirect.
  task automatic test_random;
    logic [AW-1:0] exp_pc;
    int idle, accepted;
    for (int i = 0; i < 256; i++)
      mem[i] = {legal_ops[$urandom_range(0, 7)], 12'($urandom)};
    do_reset();
    mem_rand = 1;
    exp_pc = 8'h00; idle = 0; accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      instr_ready   = ($urandom_range(0, 2) != 0);
      branch_taken  = ($urandom_range(0, 19) == 0);
      branch_target = 8'($urandom);
      if (branch_taken) exp_pc = branch_target;
      else if (instr_valid && instr_ready) begin
        vectors++;
        if ({op_code, rs, rt, rd_imm} !== mem[exp_pc] || instr_pc !== exp_pc) begin
          miscompares++;
          $display("FAIL random_instr: got %h@%h want %h@%h",
                   {op_code, rs, rt, rd_imm}, instr_pc, mem[exp_pc], exp_pc);
        end
        exp_pc = exp_pc + 8'd1;
        idle = 0; accepted++;
      end
      idle++;
      if (idle > 200) begin
        vectors++; miscompares++;
        $display("FAIL random_stuck: no acceptance for 200 cycles");
        break;
      end
      tick();
    end
    branch_taken = 1'b0; instr_ready = 1'b0; mem_rand = 0;
    vectors++;
    if (illegal_op !== 1'b0 || accepted < 100) begin
      miscompares++;
      $display("FAIL random_end: got ill=%b accepted=%0d want 0 and >=100", illegal_op, accepted);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_illegal();
    test_wrap_async();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
